// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: next-PC select codes, reset/IM
// defaults, instruction field positions and the branch-target helper.
package fetch_stage_pkg;

  typedef enum logic [2:0] {
    NPC_SEQ = 3'd0,
    NPC_BEQ = 3'd1,
    NPC_J   = 3'd2,
    NPC_JR  = 3'd3
  } npc_mode_e;

  localparam logic [31:0]  PC_RESET_DEF      = 32'h0000_3000;
  localparam logic [31:0]  IM_BASE_DEF       = 32'h0000_3000;
  localparam int unsigned  IM_WORDS_LOG2_DEF = 10;

  // Instruction field positions
  localparam int unsigned IMM16_MSB = 15;
  localparam int unsigned IMM16_LSB = 0;
  localparam int unsigned TGT26_MSB = 25;
  localparam int unsigned TGT26_LSB = 0;

  // beq target: pc + 4 + sign-extended word offset, wrapping modulo 2**32
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_npc.sv
// Combinational next-PC mux. Targets are built from the instruction held in D,
// so the delay-slot instruction in F is always kept.
module fetch_stage_npc
  import fetch_stage_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_d_pc,
  input  logic [31:0] i_d_instr,
  input  logic        i_d_cmp_taken,
  input  logic [31:0] i_d_rs_value,
  input  logic [2:0]  i_mode,
  output logic [31:0] o_npc
);

  logic [31:0] w_pc4;
  logic [31:0] w_d_pc4;
  logic [31:0] w_beq_tgt;
  logic [31:0] w_j_tgt;
  logic [5:0]  w_unused_opcode;

  assign w_pc4           = i_pc + 32'd4;
  assign w_d_pc4         = i_d_pc + 32'd4;
  assign w_beq_tgt       = branch_target(i_d_pc, i_d_instr[IMM16_MSB:IMM16_LSB]);
  assign w_j_tgt         = {w_d_pc4[31:28], i_d_instr[TGT26_MSB:TGT26_LSB], 2'b00};
  assign w_unused_opcode = i_d_instr[31:26];

  // Select next PC; undefined codes fall back to sequential
  always_comb begin
    o_npc = w_pc4;
    case (i_mode)
      NPC_SEQ: o_npc = w_pc4;
      NPC_BEQ: o_npc = i_d_cmp_taken ? w_beq_tgt : w_pc4;
      NPC_J:   o_npc = w_j_tgt;
      NPC_JR:  o_npc = i_d_rs_value;
      default: o_npc = w_pc4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage plus F/D pipeline register: owns the PC, drives the IM address,
// flags bad fetch addresses and captures the fetched word into D.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET      = PC_RESET_DEF,
  parameter logic [31:0] IM_BASE       = IM_BASE_DEF,
  parameter int unsigned IM_WORDS_LOG2 = IM_WORDS_LOG2_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cw_f_pc_enable,
  input  logic        cw_d_pff_enable,
  input  logic [2:0]  cw_f_npc_jump_mode,
  input  logic        d_cmp_taken,
  input  logic [31:0] d_rs_value,
  output logic [31:0] f_im_addr,
  input  logic [31:0] f_im_rdata,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic        f_addr_err
);

  // 33 bits so a full 2**32-byte window is still representable
  localparam logic [32:0] IM_BYTES = 33'd4 << IM_WORDS_LOG2;

  logic [31:0] r_pc;
  logic [31:0] r_d_instr;
  logic [31:0] r_d_pc;
  logic [31:0] w_npc;
  logic [31:0] w_im_off;

  fetch_stage_npc u_npc (
    .i_pc          (r_pc),
    .i_d_pc        (r_d_pc),
    .i_d_instr     (r_d_instr),
    .i_d_cmp_taken (d_cmp_taken),
    .i_d_rs_value  (d_rs_value),
    .i_mode        (cw_f_npc_jump_mode),
    .o_npc         (w_npc)
  );

  // Unsigned offset: a PC below IM_BASE wraps to a huge value and errs
  assign w_im_off   = r_pc - IM_BASE;
  assign f_addr_err = (r_pc[1:0] != 2'b00) || ({1'b0, w_im_off} >= IM_BYTES);
  assign f_im_addr  = r_pc;

  // PC register: loads next-PC when enabled, reset overrides everything
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_pc <= PC_RESET;
    else if (cw_f_pc_enable)
      r_pc <= w_npc;
  end

  // F/D register: a bad fetch address turns the captured word into a nop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d_instr <= '0;
      r_d_pc    <= PC_RESET;
    end else if (cw_d_pff_enable) begin
      r_d_instr <= f_addr_err ? '0 : f_im_rdata;
      r_d_pc    <= r_pc;
    end
  end

  assign d_instr = r_d_instr;
  assign d_pc    = r_d_pc;
  assign d_pc8   = r_d_pc + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small instruction-memory model and an
// expectation queue checked one cycle at a time.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cw_f_pc_enable;
  logic        cw_d_pff_enable;
  logic [2:0]  cw_f_npc_jump_mode;
  logic        d_cmp_taken;
  logic [31:0] d_rs_value;
  logic [31:0] f_im_addr;
  logic [31:0] f_im_rdata;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;
  logic        f_addr_err;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] dpc;
    logic        err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_stage #(
    .PC_RESET      (32'h0000_3000),
    .IM_BASE       (32'h0000_3000),
    .IM_WORDS_LOG2 (10)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cw_f_pc_enable     (cw_f_pc_enable),
    .cw_d_pff_enable    (cw_d_pff_enable),
    .cw_f_npc_jump_mode (cw_f_npc_jump_mode),
    .d_cmp_taken        (d_cmp_taken),
    .d_rs_value         (d_rs_value),
    .f_im_addr          (f_im_addr),
    .f_im_rdata         (f_im_rdata),
    .d_instr            (d_instr),
    .d_pc               (d_pc),
    .d_pc8              (d_pc8),
    .f_addr_err         (f_addr_err)
  );

  // Program image: 3000 jal 0x0c00, 3008 beq -7, 3010 jr, rest distinct fillers
  function automatic logic [31:0] im_word(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - 32'h0000_3000;
    if (off >= 32'd64) return 32'hdead_beef;
    case (off[5:2])
      4'd0:    return 32'h0c00_0c00;
      4'd2:    return 32'h1000_fff9;
      4'd4:    return 32'h03e0_0008;
      default: return {28'h2400_000, off[5:2]};
    endcase
  endfunction

  // Combinational IM read (ignores alignment, so misaligned reads return data)
  always_comb f_im_rdata = im_word(f_im_addr);

  task automatic step(input logic rst, input logic pc_en, input logic pff_en,
                      input logic [2:0] mode, input logic taken, input logic [31:0] rs,
                      input string tag, input logic [31:0] e_addr,
                      input logic [31:0] e_instr, input logic [31:0] e_dpc,
                      input logic e_err);
    exp_t e;
    exp_t got;
    rst_n              = rst;
    cw_f_pc_enable     = pc_en;
    cw_d_pff_enable    = pff_en;
    cw_f_npc_jump_mode = mode;
    d_cmp_taken        = taken;
    d_rs_value         = rs;
    e.tag = tag; e.addr = e_addr; e.instr = e_instr; e.dpc = e_dpc; e.err = e_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    n_assert++;
    assert (f_im_addr === got.addr) else begin
      n_fail++;
      $error("FAIL %s f_im_addr got %h expected %h", got.tag, f_im_addr, got.addr);
    end
    n_assert++;
    assert (d_instr === got.instr) else begin
      n_fail++;
      $error("FAIL %s d_instr got %h expected %h", got.tag, d_instr, got.instr);
    end
    n_assert++;
    assert (d_pc === got.dpc) else begin
      n_fail++;
      $error("FAIL %s d_pc got %h expected %h", got.tag, d_pc, got.dpc);
    end
    n_assert++;
    assert (d_pc8 === got.dpc + 32'd8) else begin
      n_fail++;
      $error("FAIL %s d_pc8 got %h expected %h", got.tag, d_pc8, got.dpc + 32'd8);
    end
    n_assert++;
    assert (f_addr_err === got.err) else begin
      n_fail++;
      $error("FAIL %s f_addr_err got %b expected %b", got.tag, f_addr_err, got.err);
    end
  endtask

  // Reset followed by plain sequential edges up to PC = 3000 + 4*n
  task automatic reset_and_run(input int unsigned n, input string tag);
    step(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, '0, {tag, "_rst"},
         32'h3000, 32'h0, 32'h3000, 1'b0);
    for (int unsigned i = 1; i <= n; i++)
      step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, '0, {tag, "_seq"},
           32'h3000 + 32'(4 * i), im_word(32'h3000 + 32'(4 * (i - 1))),
           32'h3000 + 32'(4 * (i - 1)), 1'b0);
  endtask

  initial begin
    // 1: reset then sequential fetch; d_pc lags f_im_addr by one edge
    reset_and_run(3, "t1");
    // 3: beq in D, not taken -> sequential, delay slot enters D
    step(1'b1, 1'b1, 1'b1, 3'd1, 1'b0, '0, "t3_beq_nt",
         32'h3010, im_word(32'h300c), 32'h300c, 1'b0);
    // undefined mode code with taken asserted behaves as sequential
    step(1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 32'h1234_5678, "mode5_seq",
         32'h3014, im_word(32'h3010), 32'h3010, 1'b0);

    // 2: beq taken -> 2ff0 below IM window, nop captured next edge
    reset_and_run(3, "t2");
    step(1'b1, 1'b1, 1'b1, 3'd1, 1'b1, '0, "t2_beq_tk",
         32'h2ff0, im_word(32'h300c), 32'h300c, 1'b1);
    step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, '0, "t2_nop",
         32'h2ff4, 32'h0, 32'h2ff0, 1'b1);

    // 4: jal at 3000 -> target {0, 0c00, 00} = 3000 after delay slot
    reset_and_run(1, "t4");
    step(1'b1, 1'b1, 1'b1, 3'd2, 1'b0, '0, "t4_jal",
         32'h3000, im_word(32'h3004), 32'h3004, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, '0, "t4_tgt",
         32'h3004, 32'h0c00_0c00, 32'h3000, 1'b0);

    // 5: jr in D with one stall cycle, then redirect to 3020
    reset_and_run(5, "t5");
    step(1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 32'h3020, "t5_stall",
         32'h3014, 32'h03e0_0008, 32'h3010, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 32'h3020, "t5_jr",
         32'h3020, im_word(32'h3014), 32'h3014, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, '0, "t5_tgt",
         32'h3024, im_word(32'h3020), 32'h3020, 1'b0);

    // 6: reset while a taken jr is in D discards the jump
    reset_and_run(5, "t6");
    step(1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 32'h3020, "t6_rst_jr",
         32'h3000, 32'h0, 32'h3000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, '0, "t6_after",
         32'h3004, 32'h0c00_0c00, 32'h3000, 1'b0);

    // 7: jr to misaligned 3002 -> error, nop into D, PC still advances
    reset_and_run(5, "t7");
    step(1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 32'h3002, "t7_jr_mis",
         32'h3002, im_word(32'h3014), 32'h3014, 1'b1);
    step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, '0, "t7_nop",
         32'h3006, 32'h0, 32'h3002, 1'b1);

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain got %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
